// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Brief    : Frame-buffer RAM arbiter: VGA reads > clear sweep > queued tracer writes.
// Revision : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
    parameter int              AW          = 13,
    parameter int              DW          = 12,
    parameter int              DEPTH       = 4,
    parameter int              MEM_WORDS   = 8192,
    parameter logic [DW-1:0]   CLEAR_COLOR = 12'h000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vga_req,
    input  logic [AW-1:0]            vga_addr,
    output logic                     vga_valid,
    output logic [DW-1:0]            vga_data,
    input  logic                     tr_valid,
    input  logic [AW-1:0]            tr_addr,
    input  logic [DW-1:0]            tr_data,
    output logic                     tr_ready,
    input  logic                     clear_req,
    output logic                     clear_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [AW-1:0]            ram_addr,
    output logic                     ram_we,
    output logic [DW-1:0]            ram_din,
    input  logic [DW-1:0]            ram_dout
);

    localparam int            PW          = $clog2(DEPTH);
    localparam int            c_LAST_INT  = MEM_WORDS - 1;
    localparam logic [AW-1:0] c_LAST_ADDR = c_LAST_INT[AW-1:0];
    localparam logic [PW:0]   c_FULL      = DEPTH[PW:0];

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_CLEAR = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_clear_done;
    logic          r_vga_valid;
    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_level;

    logic w_push;
    logic w_pop;
    logic w_clr_wr;

    assign tr_ready   = rst && (r_state == c_IDLE) && (r_level < c_FULL);
    assign w_push     = tr_valid && tr_ready;
    assign w_clr_wr   = !vga_req && (r_state == c_CLEAR);
    assign w_pop      = !vga_req && ((r_state == c_IDLE) || (r_state == c_DRAIN)) && (r_level != '0);

    assign busy       = (r_state != c_IDLE);
    assign clear_done = r_clear_done;
    assign fifo_level = r_level;
    assign vga_valid  = r_vga_valid;
    // RAM has one cycle of read latency, so the word is on ram_dout while valid is high.
    assign vga_data   = r_vga_valid ? ram_dout : '0;

    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (vga_req) begin
            ram_addr = vga_addr;
        end else if (w_clr_wr) begin
            ram_addr = r_clr_cnt;
            ram_we   = 1'b1;
            ram_din  = CLEAR_COLOR;
        end else if (w_pop) begin
            ram_addr = r_fifo_addr[r_rd_ptr];
            ram_we   = 1'b1;
            ram_din  = r_fifo_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= tr_addr;
            r_fifo_data[r_wr_ptr] <= tr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_clr_cnt    <= '0;
            r_clear_done <= 1'b0;
            r_vga_valid  <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
        end else begin
            r_vga_valid  <= vga_req;
            r_clear_done <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            case (r_state)
                c_IDLE: begin
                    if (clear_req) r_state <= c_DRAIN;
                end
                c_DRAIN: begin
                    if (r_level == '0) begin
                        r_state   <= c_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                c_CLEAR: begin
                    if (w_clr_wr) begin
                        if (r_clr_cnt == c_LAST_ADDR) begin
                            r_state      <= c_IDLE;
                            r_clear_done <= 1'b1;
                            r_clr_cnt    <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, frame-buffer address width.
REQ-002 SHALL have parameter DW, default 12, pixel width (4:4:4 RGB).
REQ-003 SHALL have parameter DEPTH, default 4, tracer write-FIFO entries (power of 2).
REQ-004 SHALL have parameter MEM_WORDS, default 8192, frame-buffer words swept by clear.
REQ-005 SHALL have parameter CLEAR_COLOR, default 12'h000, pixel value written by clear.
REQ-006 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port vga_req  in  1  VGA read request, one word per cycle.
REQ-009 SHALL have port vga_addr  in  AW  VGA read address.
REQ-010 SHALL have port vga_valid  out  1  read data valid.
REQ-011 SHALL have port vga_data  out  DW  read data.
REQ-012 SHALL have port tr_valid  in  1  tracer write offer.
REQ-013 SHALL have port tr_addr  in  AW  tracer write address.
REQ-014 SHALL have port tr_data  in  DW  tracer write pixel.
REQ-015 SHALL have port tr_ready  out  1  write accepted this cycle when tr_valid=1.
REQ-016 SHALL have port clear_req  in  1  one-cycle pulse: fill buffer with CLEAR_COLOR.
REQ-017 SHALL have port clear_done  out  1  one-cycle pulse at clear completion.
REQ-018 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-019 SHALL have port fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-020 SHALL have ports ram_addr out AW, ram_we out 1, ram_din out DW, ram_dout in DW: single-port synchronous RAM, 1-cycle read latency.

Function
REQ-021 SHALL issue at most one RAM operation per cycle; priority: VGA read > clear write > FIFO write.
REQ-022 SHALL, on vga_req=1, drive ram_addr=vga_addr, ram_we=0 combinationally in that cycle, in every state.
REQ-023 SHALL assert vga_valid exactly 1 cycle after each vga_req cycle with vga_data=ram_dout; back-to-back requests give back-to-back valid.
REQ-024 SHALL push {tr_addr,tr_data} into the FIFO when tr_valid&&tr_ready; tr_ready = rst && state==IDLE && fifo_level<DEPTH.
REQ-025 SHALL pop FIFO head to RAM (ram_we=1, head address/data) in any cycle with vga_req=0, state in {IDLE,DRAIN}, FIFO non-empty; earliest RAM write is the cycle after acceptance.
REQ-026 SHALL allow push and pop in the same cycle; fifo_level unchanged; order strictly FIFO; pointers wrap modulo DEPTH.
REQ-027 SHALL implement states IDLE, DRAIN, CLEAR.
REQ-028 SHALL move IDLE->DRAIN on clear_req; clear_req outside IDLE is ignored.
REQ-029 SHALL move DRAIN->CLEAR in the cycle after the FIFO becomes empty (immediately next cycle if already empty), clear counter=0.
REQ-030 SHALL, in CLEAR, on each cycle with vga_req=0, write CLEAR_COLOR at counter and increment; vga_req cycles stall the counter.
REQ-031 SHALL, after writing address MEM_WORDS-1, pulse clear_done for one cycle (the next cycle) and return to IDLE.
REQ-032 SHALL drive ram_addr=0, ram_we=0, ram_din=0 in cycles with no operation.
REQ-033 SHALL never drop or duplicate an accepted tracer write.

Reset
REQ-034 SHALL, while rst=0, clear FIFO (level 0), state IDLE, counter 0, vga_valid=0, vga_data=0, clear_done=0, busy=0, tr_ready=0, ram_we=0.
REQ-035 SHALL, on reset mid-CLEAR or mid-DRAIN, abort without clear_done; queued writes discarded.
REQ-036 SHALL have tr_ready=1 in the first cycle after rst deasserts.

Verification
REQ-037 Read: write 12'hABC at 13'h0100 via tracer, idle, vga_req addr 13'h0100 -> vga_valid next cycle, vga_data=12'hABC.
REQ-038 Contention: vga_req held high 10 cycles, 4 tracer writes offered -> 4 accepted, 5th sees tr_ready=0, fifo_level=4, ram_we=0 throughout; vga_req low -> 4 writes in order over 4 cycles.
REQ-039 Simultaneous: level 2, push+pop same cycle -> level stays 2, RAM writes in acceptance order.
REQ-040 Clear: 2 writes queued, clear_req -> DRAIN 2 writes, CLEAR 8192 writes of 12'h000 (plus stalls for vga_req every 4th cycle), clear_done single pulse, busy low after; readback addr 13'h1FFF = 12'h000.
REQ-041 Reset mid-clear at counter 13'h0800 -> no clear_done, state IDLE, fifo_level=0, tr_ready=1 the cycle after release.
